// File: rtl/dmem_pipe.sv
// Single-port data memory with a valid/ready request port, byte-lane writes,
// a pipelined registered read, an out-of-range error flag and an optional zero-fill sweep.
module dmem_pipe #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned INIT_ZERO = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                init_busy
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    if ((DATA_W % 8) != 0) begin : g_chk_data_w
        $error("DATA_W must be a multiple of 8");
    end
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_chk_rd_lat
        $error("RD_LAT must be in 1..3");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_chk_depth
        $error("DEPTH must be in 1..2**ADDR_W");
    end

    logic              state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              pv_q   [RD_LAT];
    logic              pv_d   [RD_LAT];
    logic              perr_q [RD_LAT];
    logic              perr_d [RD_LAT];
    logic [DATA_W-1:0] pdat_q [RD_LAT];
    logic [DATA_W-1:0] pdat_d [RD_LAT];

    logic             accept;
    logic             in_range;
    logic             wr_en;
    logic             init_we;
    logic [IDX_W-1:0] idx;

    // Gating with rst_n keeps the port closed and the array untouched while reset is held.
    assign req_ready = (state_q == ST_RUN) && rst_n;
    assign init_we   = (state_q == ST_INIT) && rst_n;
    assign init_busy = (state_q == ST_INIT);
    assign accept    = req_valid && req_ready;
    assign in_range  = (32'(req_addr) < DEPTH);
    assign wr_en     = accept && req_we && in_range;
    assign idx       = req_addr[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + IDX_W'(1);
            end
        end
    end

    // Stage 0 captures the pre-edge array value; later stages only delay it.
    always_comb begin
        pv_d[0]   = accept;
        perr_d[0] = accept && !in_range;
        pdat_d[0] = (accept && !req_we && in_range) ? mem[idx] : '0;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pv_d[i]   = pv_q[i-1];
            perr_d[i] = perr_q[i-1];
            pdat_d[i] = pdat_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pv_q[i]   <= 1'b0;
                perr_q[i] <= 1'b0;
                pdat_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pv_q[i]   <= pv_d[i];
                perr_q[i] <= perr_d[i];
                pdat_q[i] <= pdat_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign resp_valid = pv_q[RD_LAT-1];
    assign resp_err   = perr_q[RD_LAT-1];
    assign resp_rdata = pdat_q[RD_LAT-1];

endmodule

// File: tb/tb_dmem_pipe.sv
// Bench for dmem_pipe: two instances (256 words/latency 1, 200 words/latency 3) share stimulus
// and are checked every cycle against a queue-based reference model plus directed vectors.
module tb_dmem_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = '0;

    logic        r0_ready, r0_valid, r0_err, r0_busy;
    logic [15:0] r0_rdata;
    logic        r1_ready, r1_valid, r1_err, r1_busy;
    logic [15:0] r1_rdata;

    always #5 clk = ~clk;

    dmem_pipe #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(1), .INIT_ZERO(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r0_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(r0_valid), .resp_rdata(r0_rdata), .resp_err(r0_err), .init_busy(r0_busy)
    );

    dmem_pipe #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .RD_LAT(3), .INIT_ZERO(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r1_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(r1_valid), .resp_rdata(r1_rdata), .resp_err(r1_err), .init_busy(r1_busy)
    );

    typedef struct {
        int          due;
        logic [15:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          inst;
        logic [15:0] exp_d;
        logic        exp_e;
    } vec_t;

    logic [15:0] mm [2][256];
    int          busy_cnt [2];
    resp_t       q0[$];
    resp_t       q1[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic int dep(input int i);
        return (i == 0) ? 256 : 200;
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic vld(input int i);
        return (i == 0) ? r0_valid : r1_valid;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) busy_cnt[i] = dep(i);
        q0.delete();
        q1.delete();
    endtask

    task automatic model_edge();
        cyc++;
        if (!rst_n) return;
        for (int i = 0; i < 2; i++) begin
            if (busy_cnt[i] > 0) begin
                busy_cnt[i]--;
                if (busy_cnt[i] == 0) begin
                    for (int a = 0; a < 256; a++) mm[i][a] = '0;
                end
            end else if (req_valid) begin
                resp_t r;
                r.due   = cyc + lat(i) - 1;
                r.err   = (int'(req_addr) >= dep(i));
                r.rdata = '0;
                if (!r.err && !req_we) r.rdata = mm[i][req_addr];
                if (!r.err && req_we) begin
                    for (int b = 0; b < 2; b++) begin
                        if (req_be[b]) mm[i][req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                    end
                end
                if (i == 0) q0.push_back(r);
                else        q1.push_back(r);
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            resp_t       f;
            logic        ev;
            logic [19:0] exp, act;
            ev = 1'b0;
            f.due = 0; f.rdata = '0; f.err = 1'b0;
            if (i == 0 && q0.size() > 0 && q0[0].due == cyc) begin
                f = q0.pop_front(); ev = 1'b1;
            end
            if (i == 1 && q1.size() > 0 && q1[0].due == cyc) begin
                f = q1.pop_front(); ev = 1'b1;
            end
            exp = {ev, f.err, f.rdata, (rst_n && busy_cnt[i] == 0), (busy_cnt[i] > 0)};
            act = (i == 0) ? {r0_valid, r0_err, r0_rdata, r0_ready, r0_busy}
                           : {r1_valid, r1_err, r1_rdata, r1_ready, r1_busy};
            check($sformatf("model_inst%0d_cyc%0d", i, cyc), 32'(act), 32'(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic req(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                       input logic [1:0] be);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int i, output logic [15:0] d, output logic e);
        int n;
        n = 0;
        while (!vld(i) && n < 8) begin
            tick();
            n++;
        end
        check($sformatf("resp_timeout_inst%0d", i), 32'(vld(i)), 32'(1));
        d = (i == 0) ? r0_rdata : r1_rdata;
        e = (i == 0) ? r0_err : r1_err;
    endtask

    task automatic count_init(output int n0, output int n1);
        n0 = 0;
        n1 = -1;
        while (r0_busy && n0 < 400) begin
            tick();
            n0++;
            if (!r1_busy && n1 < 0) n1 = n0;
        end
    endtask

    vec_t        tab [11];
    logic [15:0] d;
    logic        e;
    int          n0, n1;

    initial begin
        tab[0]  = '{1'b0, 8'hFF, 16'h0000, 2'b00, 0, 16'h0000, 1'b0};
        tab[1]  = '{1'b1, 8'h10, 16'h1234, 2'b01, 0, 16'h0000, 1'b0};
        tab[2]  = '{1'b0, 8'h10, 16'h0000, 2'b00, 0, 16'hA534, 1'b0};
        tab[3]  = '{1'b1, 8'h10, 16'hFFFF, 2'b00, 0, 16'h0000, 1'b0};
        tab[4]  = '{1'b0, 8'h10, 16'h0000, 2'b00, 1, 16'hA534, 1'b0};
        tab[5]  = '{1'b1, 8'hC8, 16'hFFFF, 2'b11, 1, 16'h0000, 1'b1};
        tab[6]  = '{1'b0, 8'hC8, 16'h0000, 2'b00, 1, 16'h0000, 1'b1};
        tab[7]  = '{1'b0, 8'hC7, 16'h0000, 2'b00, 1, 16'h0000, 1'b0};
        tab[8]  = '{1'b0, 8'hC8, 16'h0000, 2'b00, 0, 16'hFFFF, 1'b0};
        tab[9]  = '{1'b1, 8'h20, 16'hBEEF, 2'b10, 0, 16'h0000, 1'b0};
        tab[10] = '{1'b0, 8'h20, 16'h0000, 2'b00, 1, 16'hBE00, 1'b0};

        model_reset();
        repeat (2) tick();
        check("reset_state", {28'd0, r0_ready, r0_valid, r0_busy, r1_busy}, 32'h3);
        rst_n = 1'b1;

        // T1: sweep length per depth
        count_init(n0, n1);
        check("t1_init_len_256", n0, 256);
        check("t1_init_len_200", n1, 200);
        check("t1_ready_after", {30'd0, r0_ready, r1_ready}, 32'h3);

        // T2: write then read next cycle, timing on both latencies
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 16'hA5A5; req_be = 2'b11;
        tick();
        check("t2_wr_resp_lat1", {r0_valid, r0_err, r0_rdata}, {14'd0, 18'h20000});
        req_we = 1'b0;
        tick();
        req_valid = 1'b0;
        check("t2_rd_resp_lat1", {r0_valid, r0_err, r0_rdata}, {14'd0, 2'b10, 16'hA5A5});
        check("t2_lat3_early", {31'd0, r1_valid}, 32'd0);
        tick();
        check("t2_wr_resp_lat3", {r1_valid, r1_err, r1_rdata}, {14'd0, 18'h20000});
        tick();
        check("t2_rd_resp_lat3", {r1_valid, r1_err, r1_rdata}, {14'd0, 2'b10, 16'hA5A5});
        repeat (4) tick();

        // T1 read, T3 byte lanes, T4 out of range, be=0
        for (int k = 0; k < 11; k++) begin
            req(tab[k].we, tab[k].addr, tab[k].wdata, tab[k].be);
            wait_resp(tab[k].inst, d, e);
            check($sformatf("vec%0d_rdata", k), 32'(d), 32'(tab[k].exp_d));
            check($sformatf("vec%0d_err", k), 32'(e), 32'(tab[k].exp_e));
            repeat (4) tick();
        end

        // T5: back-to-back reads through the 3-deep pipeline
        for (int j = 0; j < 4; j++) req(1'b1, 8'(j), 16'h1110 + 16'(j), 2'b11);
        repeat (4) tick();
        for (int j = 0; j < 8; j++) begin
            req_valid = (j < 4); req_we = 1'b0; req_addr = 8'(j);
            tick();
            if (j >= 2 && j <= 5)
                check($sformatf("t5_pulse%0d", j), {r1_valid, r1_rdata}, {15'd0, 1'b1, 16'h1110 + 16'(j - 2)});
            else
                check($sformatf("t5_idle%0d", j), {r1_valid, r1_rdata}, 32'd0);
        end
        req_valid = 1'b0;
        repeat (4) tick();

        for (int c = 0; c < 400; c++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = 1'($urandom_range(0, 1));
            req_wdata = 16'($urandom);
            req_be    = 2'($urandom_range(0, 3));
            case (sel)
                0:       req_addr = 8'($urandom_range(0, 7));
                1:       req_addr = 8'($urandom_range(192, 207));
                2:       req_addr = 8'($urandom_range(248, 255));
                default: req_addr = 8'($urandom);
            endcase
            tick();
        end

        // T6: reset with responses in flight, then reset mid-sweep
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h01;
        tick();
        tick();
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        check("t6_inflight_dropped", {30'd0, r0_valid, r1_valid}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (100) tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        check("t6_midinit_reset", {30'd0, r0_busy, r0_ready}, 32'h2);
        tick();
        tick();
        rst_n = 1'b1;
        count_init(n0, n1);
        check("t6_init_len_256", n0, 256);
        check("t6_init_len_200", n1, 200);
        req(1'b0, 8'h10, 16'h0000, 2'b00);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
